pipeline_controller: RTL

- Sequencing/hazard controller for the 16-bit fetch/decode/execute processor.
- Owns the program counter and gates fetch advance and decode-to-execute issue.
- Tracks pending destination writes of the 8 architectural registers in a scoreboard, and stalls on RAW/WAW hazards.
- Provides start/halt control and a stall watchdog.

---
 rtl/pipeline_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - PC owner, issue gating, register scoreboard and stall watchdog
// Optional build macro: PIPECTL_PERF_EN adds perf_issued/perf_stalls counters.
module pipeline_controller #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int          STALL_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dec_valid,
  input  logic [2:0]  dec_rs1,
  input  logic [2:0]  dec_rs2,
  input  logic        dec_use_rs2,
  input  logic [2:0]  dec_rd,
  input  logic        dec_wr,
  input  logic        dec_halt,
  input  logic        wb_valid,
  input  logic [2:0]  wb_rd,
  output logic [15:0] pc,
  output logic        pc_en,
  output logic        issue,
  output logic        stall,
  output logic        halted,
  output logic        timeout,
  output logic [7:0]  pending
`ifdef PIPECTL_PERF_EN
  ,
  output logic [15:0] perf_issued,
  output logic [15:0] perf_stalls
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [7:0] TIMEOUT_CNT = 8'(STALL_TIMEOUT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] stall_cnt;
  logic [7:0] wb_mask;
  logic [7:0] set_mask;
  logic [7:0] p_eff;
  logic       hazard;
  logic       restart;
  logic       wd_fire;

  // A writeback landing this cycle already clears its bit for hazard purposes.
  assign wb_mask  = wb_valid ? (8'b1 << wb_rd) : 8'b0;
  assign set_mask = (issue & dec_wr) ? (8'b1 << dec_rd) : 8'b0;
  assign p_eff    = pending & ~wb_mask;
  assign hazard   = dec_valid & (p_eff[dec_rs1] | (dec_use_rs2 & p_eff[dec_rs2]) | (dec_wr & p_eff[dec_rd]));
  assign restart  = start & ((state == S_IDLE) | (state == S_HALT));
  assign halted   = (state == S_HALT);

  // Next state and the combinational fetch/issue/stall enables.
  always_comb begin
    state_nxt = state;
    pc_en     = 1'b0;
    issue     = 1'b0;
    stall     = 1'b0;
    wd_fire   = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (dec_valid & dec_halt) begin
          state_nxt = S_HALT;
        end else if (hazard) begin
          stall     = 1'b1;
          state_nxt = S_STALL;
        end else begin
          pc_en = 1'b1;
          issue = dec_valid;
        end
      end
      S_STALL: begin
        if (hazard) begin
          stall = 1'b1;
          if (stall_cnt == TIMEOUT_CNT) begin
            state_nxt = S_HALT;
            wd_fire   = 1'b1;
          end
        end else begin
          pc_en     = 1'b1;
          issue     = dec_valid;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered state: FSM, PC, scoreboard, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      pending   <= 8'b0;
      timeout   <= 1'b0;
      stall_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        pc        <= RESET_PC;
        pending   <= 8'b0;
        timeout   <= 1'b0;
        stall_cnt <= 8'd0;
      end else begin
        if (pc_en) pc <= pc + 16'd1;
        pending <= (pending & ~wb_mask) | set_mask;
        if (wd_fire) timeout <= 1'b1;
        if (stall & (state == S_RUN)) stall_cnt <= 8'd1;
        else if (stall & ~wd_fire)    stall_cnt <= stall_cnt + 8'd1;
        else                          stall_cnt <= 8'd0;
      end
    end
  end

`ifdef PIPECTL_PERF_EN
  // Saturating issue and stall cycle counters, cleared on reset and start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued <= 16'd0;
      perf_stalls <= 16'd0;
    end else if (restart) begin
      perf_issued <= 16'd0;
      perf_stalls <= 16'd0;
    end else begin
      if (issue && perf_issued != 16'hFFFF) perf_issued <= perf_issued + 16'd1;
      if (stall && perf_stalls != 16'hFFFF) perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule
